switch_priority_encoder: RTL and testbench

- Inverse of the board's 4-to-16 decoder path: turns the 16 board switches into a registered 4-bit binary code for the highest-numbered active switch.
- Synchronizes and debounces raw switch inputs, then priority-encodes the stable vector.
- Reports each code change as a buffered event over a valid/ready handshake, so downstream logic such as a display driver or the decoder test loop never misses a change.

---
 rtl/switch_enc_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 46 ++++
 rtl/switch_priority_encoder.sv | 92 +++++++++
 tb/tb_switch_priority_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_enc_pkg.sv
// Shared types and the priority-encode helper for the switch encoder.
// Imported by sw_debounce and switch_priority_encoder.
package switch_enc_pkg;

   localparam int SW_W   = 16;
   localparam int CODE_W = 4;

   typedef logic [SW_W-1:0]   sw_vec_t;
   typedef logic [CODE_W-1:0] code_t;

   typedef struct packed {
      logic  valid;
      code_t code;
   } enc_evt_t;

   // Highest set index wins because later iterations overwrite earlier ones.
   function automatic code_t prio_enc(input sw_vec_t v);
      code_t c;
      c = '0;
      for (int i = 0; i < SW_W; i++) begin
         if (v[i]) c = code_t'(i);
      end
      return c;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus per-vector debounce counter; stable only follows
// the synchronized input after DEBOUNCE_CYCLES unchanged cycles.
module sw_debounce
   import switch_enc_pkg::*;
#(
   parameter int DATA_W          = SW_W,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] stable
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [DATA_W-1:0] sync_p0;
   logic [DATA_W-1:0] sync_p1;
   logic [DATA_W-1:0] sync_p2;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         sync_p2 <= '0;
         stable  <= '0;
         cnt     <= '0;
      end else begin
         sync_p0 <= sw;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         // sync_p2 is last cycle's synchronized value: any movement restarts the window.
         if ((sync_p1 != sync_p2) || (sync_p1 == stable)) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync_p1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_priority_encoder.sv
// Debounced 16-switch priority encoder with a one-entry change-event buffer.
// Optional macro SWITCH_ENC_MULTI_DETECT_EN enables the registered multi flag.
module switch_priority_encoder
   import switch_enc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [SW_W-1:0]   SW,
   input  logic              en,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic              multi,
   output logic              evt_valid,
   output logic [CODE_W:0]   evt_code,
   input  logic              evt_ready,
   output logic              evt_overrun
);

   sw_vec_t  stable;
   enc_evt_t enc_nxt;
   enc_evt_t enc_p0;
   enc_evt_t evt_p0;
   logic     chg;

   sw_debounce #(
      .DATA_W          (SW_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .n_rst  (n_rst),
      .sw     (SW),
      .stable (stable)
   );

   always_comb begin
      enc_nxt = '0;
      if (en) begin
         enc_nxt.valid = (stable != '0);
         enc_nxt.code  = prio_enc(stable);
      end
   end

   assign chg = (enc_nxt != enc_p0);

   // Encoder register and event buffer share one edge so evt_code tracks code.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         enc_p0      <= '0;
         evt_p0      <= '0;
         evt_valid   <= 1'b0;
         evt_overrun <= 1'b0;
      end else begin
         enc_p0 <= enc_nxt;
         if (chg) begin
            evt_p0    <= enc_nxt;
            evt_valid <= 1'b1;
            if (evt_valid && !evt_ready) evt_overrun <= 1'b1;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

   assign code     = enc_p0.code;
   assign valid    = enc_p0.valid;
   assign evt_code = evt_p0;

`ifdef SWITCH_ENC_MULTI_DETECT_EN
   function automatic logic many_set(input sw_vec_t v);
      int n;
      n = 0;
      for (int i = 0; i < SW_W; i++) begin
         if (v[i]) n++;
      end
      return (n > 1);
   endfunction

   logic multi_p0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) multi_p0 <= 1'b0;
      else        multi_p0 <= en && many_set(stable);
   end

   assign multi = multi_p0;
`else
   assign multi = 1'b0;
`endif

endmodule

// File: tb/tb_switch_priority_encoder.sv
// Directed bench for switch_priority_encoder with DEBOUNCE_CYCLES = 4.
module tb_switch_priority_encoder;

   logic        clk;
   logic        n_rst;
   logic [15:0] sw;
   logic        en;
   logic [3:0]  code;
   logic        valid;
   logic        multi;
   logic        evt_valid;
   logic [4:0]  evt_code;
   logic        evt_ready;
   logic        evt_overrun;

   int checks = 0;
   int errors = 0;

`ifdef SWITCH_ENC_MULTI_DETECT_EN
   localparam logic MULTI_ON = 1'b1;
`else
   localparam logic MULTI_ON = 1'b0;
`endif

   switch_priority_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .SW          (sw),
      .en          (en),
      .code        (code),
      .valid       (valid),
      .multi       (multi),
      .evt_valid   (evt_valid),
      .evt_code    (evt_code),
      .evt_ready   (evt_ready),
      .evt_overrun (evt_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sw;
      logic        en;
      logic        rdy;
      int          cyc;
      logic [3:0]  code;
      logic        valid;
      logic        ev;
      logic [4:0]  evc;
      logic        ovr;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_evt(input int maxc, output int n);
      n = 0;
      while (n < maxc) begin
         @(negedge clk);
         n++;
         if (evt_valid) break;
      end
   endtask

   task automatic chk_lat(input string nm, input int n);
      checks++;
      if (n < 6 || n > 8) begin
         errors++;
         $display("FAIL %s: latency %0d cycles, expected 6..8", nm, n);
      end
   endtask

   task automatic ack(input string nm);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      chk(nm, 16'(evt_valid), 16'h0);
   endtask

   initial begin
      int lat;

      vecs[0]  = '{16'h0001, 1'b1, 1'b0, 10, 4'd0, 1'b1, 1'b1, 5'h10, 1'b0};
      vecs[1]  = '{16'h0010, 1'b1, 1'b0, 10, 4'd4, 1'b1, 1'b1, 5'h14, 1'b1};
      vecs[2]  = '{16'h0100, 1'b1, 1'b0, 10, 4'd8, 1'b1, 1'b1, 5'h18, 1'b1};
      vecs[3]  = '{16'h0100, 1'b1, 1'b1,  1, 4'd8, 1'b1, 1'b0, 5'h18, 1'b1};
      vecs[4]  = '{16'h0100, 1'b1, 1'b0,  3, 4'd8, 1'b1, 1'b0, 5'h18, 1'b1};
      vecs[5]  = '{16'h0040, 1'b1, 1'b0, 10, 4'd6, 1'b1, 1'b1, 5'h16, 1'b1};
      vecs[6]  = '{16'h0040, 1'b1, 1'b1,  1, 4'd6, 1'b1, 1'b0, 5'h16, 1'b1};
      vecs[7]  = '{16'h0040, 1'b0, 1'b0,  1, 4'd0, 1'b0, 1'b1, 5'h00, 1'b1};
      vecs[8]  = '{16'h0040, 1'b0, 1'b1,  1, 4'd0, 1'b0, 1'b0, 5'h00, 1'b1};
      vecs[9]  = '{16'h0040, 1'b1, 1'b0,  1, 4'd6, 1'b1, 1'b1, 5'h16, 1'b1};
      vecs[10] = '{16'h0040, 1'b1, 1'b1,  1, 4'd6, 1'b1, 1'b0, 5'h16, 1'b1};
      vecs[11] = '{16'h0040, 1'b0, 1'b0,  1, 4'd0, 1'b0, 1'b1, 5'h00, 1'b1};
      vecs[12] = '{16'h0040, 1'b0, 1'b1,  1, 4'd0, 1'b0, 1'b0, 5'h00, 1'b1};
      vecs[13] = '{16'h0200, 1'b0, 1'b0, 10, 4'd0, 1'b0, 1'b0, 5'h00, 1'b1};
      vecs[14] = '{16'h0200, 1'b1, 1'b0,  1, 4'd9, 1'b1, 1'b1, 5'h19, 1'b1};
      vecs[15] = '{16'h0200, 1'b0, 1'b0,  1, 4'd0, 1'b0, 1'b1, 5'h00, 1'b1};
      vecs[16] = '{16'h0200, 1'b1, 1'b1,  1, 4'd9, 1'b1, 1'b1, 5'h19, 1'b1};
      vecs[17] = '{16'h0200, 1'b1, 1'b1,  1, 4'd9, 1'b1, 1'b0, 5'h19, 1'b1};
      vecs[18] = '{16'h0200, 1'b1, 1'b0,  1, 4'd9, 1'b1, 1'b0, 5'h19, 1'b1};

      // Reset with all switches on, then the first debounced event.
      n_rst = 1'b0;
      sw = 16'hFFFF;
      en = 1'b1;
      evt_ready = 1'b0;
      step(3);
      chk("rst_code", 16'(code), 16'h0);
      chk("rst_valid", 16'(valid), 16'h0);
      chk("rst_multi", 16'(multi), 16'h0);
      chk("rst_evt_valid", 16'(evt_valid), 16'h0);
      chk("rst_evt_code", 16'(evt_code), 16'h0);
      chk("rst_overrun", 16'(evt_overrun), 16'h0);
      n_rst = 1'b1;
      wait_evt(12, lat);
      chk_lat("rel_latency", lat);
      chk("rel_code", 16'(code), 16'hF);
      chk("rel_valid", 16'(valid), 16'h1);
      chk("rel_evt_code", 16'(evt_code), 16'h1F);
      chk("rel_multi", 16'(multi), 16'(MULTI_ON));
      ack("rel_ack");
      step(10);
      chk("rel_single_evt", 16'(evt_valid), 16'h0);

      // Clear to zero, then a 3-cycle glitch that must be filtered.
      sw = 16'h0000;
      step(10);
      chk("zero_evt_code", 16'(evt_code), 16'h00);
      chk("zero_evt_valid", 16'(evt_valid), 16'h1);
      ack("zero_ack");
      sw = 16'h0008;
      step(3);
      sw = 16'h0000;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk($sformatf("glitch_valid_%0d", i), 16'(valid), 16'h0);
         chk($sformatf("glitch_evt_%0d", i), 16'(evt_valid), 16'h0);
      end
      sw = 16'h0008;
      step(10);
      chk("hold_code", 16'(code), 16'h3);
      chk("hold_evt_code", 16'(evt_code), 16'h13);
      ack("hold_ack");

      // Lower-priority bits must not raise events.
      sw = 16'h0009;
      step(10);
      chk("prio9_evt", 16'(evt_valid), 16'h0);
      chk("prio9_code", 16'(code), 16'h3);
      chk("prio9_multi", 16'(multi), 16'(MULTI_ON));
      sw = 16'h000B;
      step(10);
      chk("prioB_evt", 16'(evt_valid), 16'h0);
      sw = 16'h0009;
      step(10);
      chk("prio9b_evt", 16'(evt_valid), 16'h0);
      sw = 16'h8009;
      step(10);
      chk("prio8009_code", 16'(code), 16'hF);
      chk("prio8009_evt_code", 16'(evt_code), 16'h1F);
      chk("prio8009_evt_valid", 16'(evt_valid), 16'h1);
      chk("prio8009_multi", 16'(multi), 16'(MULTI_ON));
      ack("prio_ack");

      // Handshake, overrun and enable vectors.
      for (int i = 0; i < 19; i++) begin
         sw = vecs[i].sw;
         en = vecs[i].en;
         evt_ready = vecs[i].rdy;
         step(vecs[i].cyc);
         chk($sformatf("v%0d_code", i), 16'(code), 16'(vecs[i].code));
         chk($sformatf("v%0d_valid", i), 16'(valid), 16'(vecs[i].valid));
         chk($sformatf("v%0d_evt_valid", i), 16'(evt_valid), 16'(vecs[i].ev));
         chk($sformatf("v%0d_evt_code", i), 16'(evt_code), 16'(vecs[i].evc));
         chk($sformatf("v%0d_overrun", i), 16'(evt_overrun), 16'(vecs[i].ovr));
         chk($sformatf("v%0d_multi", i), 16'(multi), 16'h0);
      end
      evt_ready = 1'b0;

      // Asynchronous reset pulse two counts into a debounce window.
      sw = 16'h0400;
      step(5);
      chk("mid_code", 16'(code), 16'h9);
      n_rst = 1'b0;
      #1;
      chk("arst_code", 16'(code), 16'h0);
      chk("arst_valid", 16'(valid), 16'h0);
      chk("arst_evt_valid", 16'(evt_valid), 16'h0);
      chk("arst_evt_code", 16'(evt_code), 16'h0);
      chk("arst_overrun", 16'(evt_overrun), 16'h0);
      @(negedge clk);
      n_rst = 1'b1;
      wait_evt(12, lat);
      chk_lat("arst_latency", lat);
      chk("arst_new_code", 16'(code), 16'hA);
      chk("arst_new_valid", 16'(valid), 16'h1);
      chk("arst_new_evt_code", 16'(evt_code), 16'h1A);
      chk("arst_new_overrun", 16'(evt_overrun), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
